text_plane_gen: RTL

Parametrised text-mode pixel generator for the VGA display path. It walks a character RAM (several 8-bit codes packed per word) and a glyph ROM, both with synchronous reads, through a three-stage pipeline. It pushes one 1-bit pixel per advancing cycle, tagged with start-of-frame/end-of-line markers, into the pixel FIFO feeding the VGA timing block. It throttles on FIFO almost-full, runs frame-by-frame under an enable, and optionally overlays a blinking block cursor.

---
 rtl/text_plane_gen.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/text_plane_gen.sv
// text_plane_gen: text-mode pixel generator; char RAM -> glyph ROM -> 1-bit pixels into the VGA pixel FIFO.
// Ports: clk/rst (async, active-high); enable starts frames; char_addr/char_rdata and font_addr/font_rdata
// are synchronous-read memory ports; fifo_wr_en/fifo_wdata {sof, eol, pixel} feed the FIFO, throttled by
// fifo_afull; busy, frame_done report progress; cursor_col/cursor_row place the block cursor.
// Optional blinking cursor overlay: define TEXT_PLANE_CURSOR_EN.
module text_plane_gen #(
    parameter int H_ACTIVE       = 640,
    parameter int V_ACTIVE       = 480,
    parameter int CHARS_PER_WORD = 3,
    parameter int FONT_H         = 8,
    parameter int ADDR_W         = 11
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    output logic [ADDR_W-1:0]             char_addr,
    input  logic [8*CHARS_PER_WORD-1:0]   char_rdata,
    output logic [7+$clog2(FONT_H):0]     font_addr,
    input  logic [7:0]                    font_rdata,
    input  logic                          fifo_afull,
    output logic                          fifo_wr_en,
    output logic [2:0]                    fifo_wdata,
    output logic                          busy,
    output logic                          frame_done,
    input  logic [6:0]                    cursor_col,
    input  logic [5:0]                    cursor_row
);
    localparam int COLS = H_ACTIVE / 8;
    localparam int WPR  = (COLS + CHARS_PER_WORD - 1) / CHARS_PER_WORD;
    localparam int FH_W = $clog2(FONT_H);
    localparam int XW   = $clog2(H_ACTIVE);
    localparam int YW   = $clog2(V_ACTIVE);
    localparam int LW   = CHARS_PER_WORD > 1 ? $clog2(CHARS_PER_WORD) : 1;
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2;

    logic [1:0]        state;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [LW-1:0]     lane;
    logic [ADDR_W-1:0] word_idx, row_base;
    logic              advance, issue, x_end, y_end, row_end, cur_hit, blink, inv;
    logic [7:0]        lane_code;
    logic              s0_valid, s0_sof, s0_eol, s0_last, s0_cur;
    logic [2:0]        s0_xb;
    logic [FH_W-1:0]   s0_gr;
    logic [LW-1:0]     s0_lane;
    logic              s1_valid, s1_sof, s1_eol, s1_last, s1_cur;
    logic [2:0]        s1_xb;
    logic              w_last;

    always_comb begin
        advance   = !fifo_afull;
        issue     = (state == RUN) && advance;
        x_end     = x == XW'(H_ACTIVE - 1);
        y_end     = y == YW'(V_ACTIVE - 1);
        row_end   = y[FH_W-1:0] == FH_W'(FONT_H - 1);
        cur_hit   = (7'(x >> 3) == cursor_col) && (6'(y >> FH_W) == cursor_row);
        lane_code = char_rdata[8*s0_lane +: 8];
        inv       = s1_cur & ~blink;
        busy      = (state != IDLE) | s0_valid | s1_valid | fifo_wr_en;
    end

    // Counters walk the frame; the text-row base steps by WPR so no multiplier is needed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            x        <= '0;
            y        <= '0;
            lane     <= '0;
            word_idx <= '0;
            row_base <= '0;
        end else if (state == IDLE) begin
            if (enable) begin
                state    <= RUN;
                x        <= '0;
                y        <= '0;
                lane     <= '0;
                word_idx <= '0;
                row_base <= '0;
            end
        end else if (issue) begin
            x <= x_end ? '0 : x + 1'b1;
            if (x_end) begin
                lane     <= '0;
                word_idx <= '0;
                y        <= y_end ? '0 : y + 1'b1;
                row_base <= y_end ? '0 : row_end ? row_base + ADDR_W'(WPR) : row_base;
                if (y_end && !enable)
                    state <= DRAIN;
            end else if (x[2:0] == 3'd7) begin
                lane     <= (lane == LW'(CHARS_PER_WORD - 1)) ? '0 : lane + 1'b1;
                word_idx <= (lane == LW'(CHARS_PER_WORD - 1)) ? word_idx + 1'b1 : word_idx;
            end
        end else if (state == DRAIN && !busy_pipe(s0_valid, s1_valid, fifo_wr_en)) begin
            state <= IDLE;
        end
    end

    function automatic logic busy_pipe(input logic a, input logic b, input logic c);
        return a | b | c;
    endfunction

    // Whole pipeline freezes on !advance so the memory outputs stay aligned with their stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            char_addr  <= '0;
            font_addr  <= '0;
            fifo_wr_en <= 1'b0;
            fifo_wdata <= '0;
            frame_done <= 1'b0;
            w_last     <= 1'b0;
            s0_valid   <= 1'b0;
            s0_sof     <= 1'b0;
            s0_eol     <= 1'b0;
            s0_last    <= 1'b0;
            s0_cur     <= 1'b0;
            s0_xb      <= '0;
            s0_gr      <= '0;
            s0_lane    <= '0;
            s1_valid   <= 1'b0;
            s1_sof     <= 1'b0;
            s1_eol     <= 1'b0;
            s1_last    <= 1'b0;
            s1_cur     <= 1'b0;
            s1_xb      <= '0;
        end else begin
            fifo_wr_en <= advance & s1_valid;
            frame_done <= fifo_wr_en & w_last;
            if (advance) begin
                s0_valid   <= issue;
                char_addr  <= row_base + word_idx;
                s0_xb      <= x[2:0];
                s0_gr      <= y[FH_W-1:0];
                s0_lane    <= lane;
                s0_sof     <= (x == '0) && (y == '0);
                s0_eol     <= x_end;
                s0_last    <= x_end && y_end;
                s0_cur     <= cur_hit;
                s1_valid   <= s0_valid;
                font_addr  <= {lane_code, s0_gr};
                s1_xb      <= s0_xb;
                s1_sof     <= s0_sof;
                s1_eol     <= s0_eol;
                s1_last    <= s0_last;
                s1_cur     <= s0_cur;
                fifo_wdata <= {s1_sof, s1_eol, font_rdata[3'd7 - s1_xb] ^ inv};
                w_last     <= s1_last;
            end
        end
    end

`ifdef TEXT_PLANE_CURSOR_EN
    logic [4:0] frame_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            frame_cnt <= '0;
        else if (frame_done)
            frame_cnt <= frame_cnt + 1'b1;
    end

    always_comb blink = frame_cnt[4];
`else
    always_comb blink = 1'b1;
`endif

endmodule
